// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: keeps at most one fetch in flight, holds each
// instruction until decode takes it, and flushes on branch/jump redirects.
module fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [31:0]           retired_cnt,
    output logic [1:0]            state_dbg
);

    // Handshakes: a fetch is accepted on a cycle with imem_req && imem_gnt; its
    // data arrives on a later cycle with imem_rvalid. An instruction is handed
    // to decode on a cycle with instr_valid && !stall; instr/instr_pc hold
    // steady while stall is high.
    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] req_pc;
    logic                  drop;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic [DATA_WIDTH-1:0] pc_seq;

    assign redirect_target = redirect_pc & ~DATA_WIDTH'(3);
    assign pc_seq          = pc + DATA_WIDTH'(4);
    assign imem_addr       = pc;
    assign state_dbg       = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            req_pc      <= '0;
            drop        <= 1'b0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            retired_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (redirect_valid) pc <= redirect_target;
                    imem_req <= 1'b1;
                    state    <= REQ;
                end
                REQ: begin
                    if (imem_gnt) begin
                        // The accepted fetch is for the old pc; a same-cycle
                        // redirect makes its response stale.
                        req_pc   <= pc;
                        pc       <= redirect_valid ? redirect_target : pc_seq;
                        drop     <= redirect_valid;
                        imem_req <= 1'b0;
                        state    <= WAIT_RSP;
                    end else if (redirect_valid) begin
                        pc <= redirect_target;
                    end
                end
                WAIT_RSP: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                        if (imem_rvalid) begin
                            drop     <= 1'b0;
                            imem_req <= 1'b1;
                            state    <= REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (drop) begin
                            drop     <= 1'b0;
                            imem_req <= 1'b1;
                            state    <= REQ;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= req_pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // A flush wins over a consume: the held instruction is lost.
                    if (redirect_valid) begin
                        pc          <= redirect_target;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                        retired_cnt <= retired_cnt + 32'd1;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios, then randomized traffic scored
// against a fetch-stream model with expected-instruction and address queues.
module tb_fetch_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [DW-1:0] redirect_pc = '0;
    logic          stall = 1'b0;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [DW-1:0] instr_pc;
    logic [31:0]   retired_cnt;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    // expected instructions {word, pc} and expected fetch addresses
    logic [63:0]   exp_q[$];
    logic [DW-1:0] addr_q[$];

    logic [31:0]   exp_cnt = '0;
    logic [31:0]   exp_ret = '0;
    logic [DW-1:0] next_fetch = '0;
    logic [DW-1:0] out_addr = '0;
    bit            out_busy = 1'b0;
    bit            out_drop = 1'b0;
    int            out_lat = 0;
    bit            mon_en = 1'b0;
    int            idle = 0;

    fetch_ctrl #(.DATA_WIDTH(DW), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .retired_cnt    (retired_cnt),
        .state_dbg      (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // one complete fetch with memory latency k and a stall of stall_cycles in HOLD
    task automatic fetch_one(input logic [31:0] a, input int k, input int stall_cycles);
        check("seq_req", {31'd0, imem_req}, 32'd1);
        check("seq_addr", imem_addr, a);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 1; i < k; i++) begin
            check("lat_valid_low", {31'd0, instr_valid}, 32'd0);
            check("wait_no_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_instr", instr, mem_word(a));
        check("hold_pc", instr_pc, a);
        stall = 1'b1;
        for (int i = 0; i < stall_cycles; i++) begin
            tick();
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instr, mem_word(a));
            check("stall_pc", instr_pc, a);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
            check("stall_cnt", retired_cnt, exp_cnt);
        end
        stall = 1'b0;
        tick();
        exp_cnt = exp_cnt + 32'd1;
        check("consume_valid", {31'd0, instr_valid}, 32'd0);
        check("consume_cnt", retired_cnt, exp_cnt);
    endtask

    // random driver: memory responder plus stimulus, updating the fetch-stream model
    task automatic drive_random(input int p_stall, input int p_redir, input int p_gnt, input int max_lat);
        bit            g;
        bit            rv;
        bit            rd;
        logic [DW-1:0] tgt;
        rd  = ($urandom_range(0, 99) < p_redir);
        tgt = $urandom;
        g   = imem_req && !out_busy && ($urandom_range(0, 99) < p_gnt);
        rv  = out_busy && (out_lat == 0);
        stall          = ($urandom_range(0, 99) < p_stall);
        redirect_valid = rd;
        redirect_pc    = tgt;
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(out_addr) : $urandom;
        if (!out_busy && $urandom_range(0, 99) < 5) imem_rvalid = 1'b1;
        if (rv) begin
            if (!(out_drop || rd)) exp_q.push_back({mem_word(out_addr), out_addr});
            out_busy = 1'b0;
        end else if (out_busy) begin
            if (rd) out_drop = 1'b1;
            out_lat--;
        end
        if (g) begin
            addr_q.push_back(next_fetch);
            out_busy = 1'b1;
            out_addr = next_fetch;
            out_drop = rd;
            out_lat  = $urandom_range(0, max_lat - 1);
        end
        if (rd) next_fetch = tgt & ~32'd3;
        else if (g) next_fetch = next_fetch + 32'd4;
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                idle++;
                check("retired_cnt", retired_cnt, exp_ret);
                if (imem_req && imem_gnt) begin
                    idle = 0;
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch_addr actual=%h expected=no_grant", imem_addr);
                    end else begin
                        check("fetch_addr", imem_addr, addr_q.pop_front());
                    end
                end
                if (instr_valid) begin
                    check("req_during_hold", {31'd0, imem_req}, 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr actual_pc=%h expected=none", instr_pc);
                    end else begin
                        check("instr", instr, exp_q[0][63:32]);
                        check("instr_pc", instr_pc, exp_q[0][31:0]);
                        if (!stall || redirect_valid) begin
                            void'(exp_q.pop_front());
                            idle = 0;
                            if (!redirect_valid) exp_ret = exp_ret + 32'd1;
                        end
                    end
                end
                if (idle > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL progress_timeout actual=%0d idle_cycles expected<=200", idle);
                    idle = 0;
                end
            end
        end
    end

    // reset, directed scenarios, random phase, report
    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_cnt", retired_cnt, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        check("boot_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);

        // sequential zero-wait fetch, then a 5-cycle stall
        fetch_one(32'h0, 1, 0);
        fetch_one(32'h4, 1, 0);
        fetch_one(32'h8, 1, 5);
        check("three_retired", retired_cnt, 32'd3);

        // redirect while a fetch is outstanding; response arrives 2 cycles later
        check("pre_redir_addr", imem_addr, 32'hC);
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("drop_wait_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'hC);
        tick();
        imem_rvalid = 1'b0;
        check("drop_valid", {31'd0, instr_valid}, 32'd0);
        check("drop_req", {31'd0, imem_req}, 32'd1);
        check("drop_next_addr", imem_addr, 32'h100);

        // stray rvalid while requesting is ignored
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("stray_valid", {31'd0, instr_valid}, 32'd0);
        check("stray_addr", imem_addr, 32'h100);
        fetch_one(32'h100, 3, 0);

        // redirect without grant, then redirect coincident with grant at 0x8
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        tick();
        check("redir_req_addr", imem_addr, 32'h8);
        check("redir_req_req", {31'd0, imem_req}, 32'd1);
        imem_gnt    = 1'b1;
        redirect_pc = 32'h43;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        check("gnt_redir_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h8);
        tick();
        imem_rvalid = 1'b0;
        check("gnt_redir_valid", {31'd0, instr_valid}, 32'd0);
        check("gnt_redir_addr", imem_addr, 32'h40);

        // consume and redirect together in HOLD: flush, no retire
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h40);
        tick();
        imem_rvalid = 1'b0;
        check("flush_hold_pc", instr_pc, 32'h40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h201;
        tick();
        redirect_valid = 1'b0;
        check("flush_valid", {31'd0, instr_valid}, 32'd0);
        check("flush_cnt", retired_cnt, exp_cnt);
        check("flush_addr", imem_addr, 32'h200);

        // async reset in WAIT_RSP with pc=0x20
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1C;
        tick();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_instr", instr, 32'h0);
        check("arst_instr_pc", instr_pc, 32'h0);
        check("arst_cnt", retired_cnt, 32'h0);
        exp_cnt = '0;
        tick();
        tick();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
        check("post_rst_valid", {31'd0, instr_valid}, 32'd0);

        // counter wrap
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h0);
        tick();
        imem_rvalid = 1'b0;
        stall = 1'b1;
        force dut.retired_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.retired_cnt;
        check("wrap_preload", retired_cnt, 32'hFFFF_FFFF);
        stall = 1'b0;
        tick();
        check("wrap_zero", retired_cnt, 32'h0);

        // randomized traffic against the model
        rst = 1'b1;
        tick();
        tick();
        next_fetch = 32'h0;
        out_busy   = 1'b0;
        out_drop   = 1'b0;
        out_lat    = 0;
        exp_ret    = '0;
        exp_q.delete();
        addr_q.delete();
        rst    = 1'b0;
        idle   = 0;
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_random(25, 8, 60, 4);
            tick();
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            drive_random(0, 0, 0, 4);
            tick();
        end
        mon_en = 1'b0;
        check("drain_instr", exp_q.size(), 32'd0);
        check("drain_addr", addr_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
